// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC control FSM: track/hold, DAC trial codes,
// one bit resolved per step; BUSY stays high through the DONE cycle.
module sar_adc_controller #(
  parameter int N_BITS        = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              CMP,
  output logic              SAMPLE,
  output logic [N_BITS-1:0] DAC_CODE,
  output logic              BUSY,
  output logic [N_BITS-1:0] DATA,
  output logic              EOC
);

  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ?
                        SAMPLE_CYCLES : SETTLE_CYCLES + 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sample_q, sample_d;
  logic [N_BITS-1:0] dac_q, dac_d;
  logic              busy_q, busy_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              eoc_q, eoc_d;

  logic [N_BITS-1:0] mask;
  logic [N_BITS-1:0] resolved;

  // Higher bits pass through untouched; current bit takes CMP, next bit is set.
  always_comb begin
    mask     = {{(N_BITS-1){1'b0}}, 1'b1} << bit_q;
    resolved = (dac_q & ~mask)
             | (CMP ? mask : '0)
             | ((bit_q != '0) ? (mask >> 1) : '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sample_d = sample_q;
    dac_d    = dac_q;
    busy_d   = busy_q;
    data_d   = data_q;
    eoc_d    = eoc_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        sample_d = 1'b0;
        eoc_d    = 1'b0;
        dac_d    = '0;
        if (START) begin
          state_d  = S_SAMPLE;
          cnt_d    = CW'(SAMPLE_CYCLES - 1);
          busy_d   = 1'b1;
          sample_d = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) begin
          state_d  = S_CONVERT;
          bit_d    = BW'(N_BITS - 1);
          dac_d    = {1'b1, {(N_BITS-1){1'b0}}};
          sample_d = 1'b0;
          cnt_d    = CW'(SETTLE_CYCLES);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CONVERT: begin
        if (cnt_q == '0) begin
          dac_d = resolved;
          if (bit_q == '0) begin
            data_d  = resolved;
            eoc_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q - 1'b1;
            cnt_d = CW'(SETTLE_CYCLES);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        eoc_d   = 1'b0;
        dac_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sample_q <= 1'b0;
      dac_q    <= '0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      eoc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      dac_q    <= dac_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      eoc_q    <= eoc_d;
    end
  end

  assign SAMPLE   = sample_q;
  assign DAC_CODE = dac_q;
  assign BUSY     = busy_q;
  assign DATA     = data_q;
  assign EOC      = eoc_q;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller with an ideal comparator model.
module tb_sar_adc_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       CMP;
  logic       SAMPLE;
  logic [9:0] DAC_CODE;
  logic       BUSY;
  logic [9:0] DATA;
  logic       EOC;
  logic [9:0] vin = '0;

  int total = 0;
  int bad   = 0;

  sar_adc_controller dut (
    .CLK(CLK), .RST(RST), .START(START), .CMP(CMP),
    .SAMPLE(SAMPLE), .DAC_CODE(DAC_CODE), .BUSY(BUSY),
    .DATA(DATA), .EOC(EOC)
  );

  always #5 CLK = ~CLK;
  assign CMP = (vin >= DAC_CODE);

  typedef struct {
    logic [9:0] vin;
    logic [9:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One conversion from the START edge until BUSY drops.
  task automatic conv(input logic [9:0] v, input logic [9:0] expd,
                      input logic [9:0] prev, input bit hold,
                      input bit pulses);
    int busy_n, eoc_n, eoc_at, dac_bad, data_bad, samp_bad;
    int k, trial;
    logic [9:0] apb;
    busy_n = 0; eoc_n = 0; eoc_at = -1;
    dac_bad = 0; data_bad = 0; samp_bad = 0;
    apb = '0;
    vin = v;
    START = 1'b1;
    tick();
    START = hold;
    for (int c = 0; c < 40; c++) begin
      if (BUSY) begin
        busy_n++;
        apb = DATA;
      end
      if (EOC) begin
        eoc_n++;
        eoc_at = c;
      end
      if (c < 4 && SAMPLE !== 1'b1) samp_bad++;
      if (c >= 4 && SAMPLE !== 1'b0) samp_bad++;
      if (c >= 4 && c < 24) begin
        k = 9 - (c - 4) / 2;
        trial = (int'(expd) & ~((1 << (k + 1)) - 1)) | (1 << k);
        if (int'(DAC_CODE) != trial) dac_bad++;
      end
      if (c < 24 && DATA !== prev) data_bad++;
      if (!BUSY) break;
      START = hold | (pulses && (c == 4 || c == 14));
      tick();
    end
    chk("busy_len", busy_n, 25);
    chk("eoc_count", eoc_n, 1);
    chk("eoc_cycle", eoc_at, 24);
    chk("dac_seq", dac_bad, 0);
    chk("data_hold", data_bad, 0);
    chk("sample", samp_bad, 0);
    chk("apb_last", int'(apb), int'(expd));
    chk("idle_data", int'(DATA), int'(expd));
    chk("idle_dac", int'(DAC_CODE), 0);
  endtask

  initial begin
    logic [9:0] prev;
    tbl[0] = '{10'h2A5, 10'h2A5};
    tbl[1] = '{10'h000, 10'h000};
    tbl[2] = '{10'h3FF, 10'h3FF};
    tbl[3] = '{10'h200, 10'h200};
    tbl[4] = '{10'h1FF, 10'h1FF};
    tbl[5] = '{10'h155, 10'h155};
    tbl[6] = '{10'h0AA, 10'h0AA};

    tick();
    tick();
    chk("rst_outs", {SAMPLE, BUSY, EOC, DAC_CODE, DATA}, 0);
    RST = 1'b0;
    tick();
    chk("idle_outs", {SAMPLE, BUSY, EOC, DAC_CODE, DATA}, 0);

    prev = '0;
    for (int i = 0; i < 7; i++) begin
      conv(tbl[i].vin, tbl[i].exp_data, prev, 1'b0, 1'b0);
      prev = tbl[i].exp_data;
      tick();
    end

    // START held high: exactly one idle cycle between conversions.
    conv(10'h155, 10'h155, prev, 1'b1, 1'b0);
    chk("gap_busy", int'(BUSY), 0);
    conv(10'h0AA, 10'h0AA, 10'h155, 1'b0, 1'b0);
    tick();

    // START pulses mid-conversion must not queue another conversion.
    conv(10'h2A5, 10'h2A5, 10'h0AA, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("no_requeue", int'(BUSY), 0);

    // Asynchronous reset mid-conversion discards everything.
    conv(10'h123, 10'h123, 10'h2A5, 1'b0, 1'b0);
    tick();
    vin = 10'h3C0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    chk("pre_rst_busy", int'(BUSY), 1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst", {SAMPLE, BUSY, EOC, DAC_CODE, DATA}, 0);
    tick();
    RST = 1'b0;
    tick();
    conv(10'h2A5, 10'h2A5, 10'h000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
